// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if -- link between the TX byte queue and a UART transmitter.
//   uart_wr   : one-cycle write strobe, queue -> transmitter
//   uart_data : byte presented with uart_wr (held until the next dequeue)
//   uart_busy : transmitter busy, rises one cycle after an accepted uart_wr
// master = queue side, slave = transmitter side.
interface uart_tx_queue_if;
  logic       uart_wr;
  logic [7:0] uart_data;
  logic       uart_busy;

  modport master (output uart_wr, uart_data, input uart_busy);
  modport slave  (input uart_wr, uart_data, output uart_busy);
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue -- byte FIFO between a CPU and a UART transmitter.
// The CPU pushes bytes; a 3-state pacer (IDLE/SEND/SETTLE) pops one byte at
// a time and strobes it into the transmitter whenever it is not busy.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   push, push_data     : enqueue one byte per high cycle
//   flush               : drop every queued byte (a byte already latched still goes out)
//   clr_ovf             : clear the sticky overflow flag
//   full, count         : occupancy (count is 0..DEPTH)
//   overflow            : sticky, a push was dropped because the queue was full
//   idle                : nothing queued, pacer in IDLE, transmitter not busy
//   uart                : uart_wr / uart_data / uart_busy towards the transmitter
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          flush,
  input  logic          clr_ovf,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          idle,
  uart_tx_queue_if.master uart
);

  typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] rptr, wptr;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          deq, acc, ovf_set;

  // Pacer: a dequeue in IDLE loads data_q, SEND strobes it, SETTLE covers
  // the one-cycle busy latency so the next IDLE sees the real busy level.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    uart.uart_wr = 1'b0;
    deq          = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !uart.uart_busy) begin
          deq       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        uart.uart_wr = 1'b1;
        state_nxt    = SETTLE;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign full = (count == (AW+1)'(DEPTH));

  // A dequeue in the same cycle frees a slot, so a push into a full queue is
  // still accepted. flush overrides any push.
  assign acc     = push && !flush && (!full || deq);
  assign ovf_set = push && !flush && full && !deq;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= uart.uart_busy;
      // Set wins over clear so a dropped byte is never lost from the flag.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (deq) data_q <= mem[rptr];
      if (flush) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (acc) wptr <= wptr + AW'(1);
        if (deq) rptr <= rptr + AW'(1);
        case ({acc, deq})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset; when full, rptr == wptr and the read above sees the
  // old byte while the new one is written.
  always_ff @(posedge clk) begin
    if (!reset && acc) mem[wptr] <= push_data;
  end

  assign uart.uart_data = data_q;

  // Busy is taken from its registered copy so idle has no input-to-output path.
  assign idle = (count == '0) && (state == IDLE) && !busy_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic [7:0]    push_data = 8'h00;
  logic          flush = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          full, overflow, idle;
  logic [AW:0]   count;

  uart_tx_queue_if u_if();

  // Transmitter model: busy rises one cycle after uart_wr and lasts busy_len
  // cycles; busy_force holds it busy regardless.
  int   busy_cnt = 0;
  int   busy_len = 10;
  logic busy_force = 1'b0;
  assign u_if.uart_busy = busy_force | (busy_cnt != 0);
  always @(posedge clk) begin
    if (u_if.uart_wr)      busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .flush(flush), .clr_ovf(clr_ovf), .full(full), .count(count),
    .overflow(overflow), .idle(idle), .uart(u_if)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  // Monitor: every strobe must carry the next expected byte, never while
  // busy, and at least 3 cycles after the previous strobe.
  int cyc = 0;
  int last_wr = -100;
  always @(negedge clk) begin
    cyc++;
    if (u_if.uart_wr) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL uart_wr_unexpected: got data %02h, required no strobe", u_if.uart_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (u_if.uart_data !== e || u_if.uart_busy || (cyc - last_wr) < 3) begin
          n_err++;
          $display("FAIL uart_wr_byte: got data %02h busy %0b gap %0d, required data %02h busy 0 gap>=3",
                   u_if.uart_data, u_if.uart_busy, cyc - last_wr, e);
        end
      end
      last_wr = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_push(input logic [7:0] b, input bit will_send);
    push = 1'b1;
    push_data = b;
    if (will_send) exp_q.push_back(b);
    tick();
    push = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && idle) && i < budget) begin
      tick();
      i++;
    end
    check(name, {31'd0, exp_q.size() == 0 && idle}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (!idle && i < budget) begin
      tick();
      i++;
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idle", idle, 1);
    check("rst_uart_wr", u_if.uart_wr, 0);
    check("rst_uart_data", u_if.uart_data, 8'h00);
    reset = 1'b0;
    tick();

    // Three back-to-back bytes, busy 10 cycles after each strobe
    busy_len = 10;
    do_push(8'h41, 1);
    check("idle_after_push", idle, 0);
    do_push(8'h42, 1);
    do_push(8'h43, 1);
    wait_drain("drain_abc", 200);

    // Fill with busy held: 16 accepted, 17th dropped
    busy_len = 2;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) do_push(8'h60 + 8'(i), 1);
    check("fill_ovf_clear", overflow, 0);
    do_push(8'hEE, 0);
    check("full_flag", full, 1);
    check("full_count", count, 16);
    check("ovf_set", overflow, 1);
    clr_ovf = 1'b1;
    do_push(8'hEF, 0);
    clr_ovf = 1'b0;
    check("ovf_clr_vs_push", overflow, 1);
    check("count_after_drop", count, 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full queue: push in the same cycle as a dequeue
    busy_force = 1'b0;
    do_push(8'h99, 1);
    check("simul_count", count, 16);
    check("simul_full", full, 1);
    check("simul_ovf", overflow, 0);
    wait_drain("drain_full", 400);

    // 40 bytes at the drain rate (one per 3 cycles)
    busy_len = 1;
    for (int i = 0; i < 40; i++) begin
      do_push(8'(i * 5 + 1), 1);
      tick();
      tick();
    end
    wait_drain("drain_stream", 100);

    // flush overrides a same-cycle push
    busy_len = 5;
    busy_force = 1'b1;
    do_push(8'h11, 0);
    do_push(8'h12, 0);
    flush = 1'b1;
    push = 1'b1;
    push_data = 8'h13;
    tick();
    flush = 1'b0;
    push = 1'b0;
    check("flush_vs_push", count, 0);

    // flush with 5 queued and one byte in SEND
    do_push(8'hA0, 1);
    for (int i = 1; i < 6; i++) do_push(8'hA0 + 8'(i), 0);
    check("pre_flush_count", count, 6);
    busy_force = 1'b0;
    tick();
    check("send_wr", u_if.uart_wr, 1);
    check("send_count", count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", count, 0);
    repeat (30) tick();
    check("flush_sent_only_one", exp_q.size(), 0);
    wait_idle("flush_idle", 30);

    // Reset during SEND
    busy_force = 1'b1;
    do_push(8'hC1, 1);
    do_push(8'hC2, 0);
    busy_force = 1'b0;
    tick();
    check("pre_rst_send", u_if.uart_wr, 1);
    reset = 1'b1;
    tick();
    check("rst_send_wr", u_if.uart_wr, 0);
    check("rst_send_count", count, 0);
    check("rst_send_ovf", overflow, 0);
    reset = 1'b0;
    wait_idle("rst_send_idle", 30);
    repeat (10) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push  input  1  write strobe from CPU; one byte per high cycle.
REQ-006 SHALL have port push_data  input  8  byte to enqueue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port clr_ovf  input  1  clear sticky overflow flag.
REQ-009 SHALL have port full  output  1  high when count == DEPTH.
REQ-010 SHALL have port count  output  AW+1  number of queued bytes, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-012 SHALL have port idle  output  1  queue empty and state IDLE and uart_busy low.
REQ-013 SHALL have port uart_wr  output  1  one-cycle write strobe to the downstream UART transmitter.
REQ-014 SHALL have port uart_data  output  8  byte presented with uart_wr.
REQ-015 SHALL have port uart_busy  input  1  transmitter busy; rises one cycle after an accepted uart_wr.

Function
REQ-016 Storage SHALL be a DEPTH x 8 array with AW-bit read/write pointers that wrap modulo DEPTH; count SHALL be a separate (AW+1)-bit register.
REQ-017 push with count < DEPTH SHALL write push_data at wptr, increment wptr; push with count == DEPTH SHALL drop the byte, leave pointers/count unchanged, set overflow.
REQ-018 overflow SHALL stay set until clr_ovf or reset; a same-cycle clr_ovf and overflowing push SHALL leave overflow set.
REQ-019 State machine SHALL have states IDLE, SEND, SETTLE.
REQ-020 IDLE: if count != 0 and uart_busy low -> SEND, with uart_data loaded from array[rptr], rptr incremented, count decremented in that same edge.
REQ-021 SEND: uart_wr SHALL be high for exactly this one cycle; next state SETTLE unconditionally.
REQ-022 SETTLE: uart_wr low; one-cycle wait covering busy latency; next state IDLE.
REQ-023 Minimum spacing between uart_wr pulses SHALL be 3 cycles; no uart_wr SHALL be issued while uart_busy is high.
REQ-024 uart_data SHALL be a register, stable from the SEND cycle until the next dequeue.
REQ-025 Simultaneous push and dequeue: count SHALL remain unchanged; when full, the dequeue frees the slot first, so the push is accepted and overflow is not set.
REQ-026 Push into an empty queue SHALL make uart_wr rise no earlier than 2 cycles after the push edge (write, then IDLE dequeue, then SEND).
REQ-027 flush SHALL set rptr = wptr = 0 and count = 0 on the next edge and SHALL override a same-cycle push.
REQ-028 flush SHALL NOT abort a SEND/SETTLE in progress; a byte already latched SHALL still be strobed.
REQ-029 full and idle SHALL be combinational from registered state only (no input-to-output paths).

Reset
REQ-030 On reset: state IDLE, rptr = wptr = 0, count = 0, overflow = 0, uart_wr = 0, uart_data = 8'h00; reset SHALL take precedence over push, flush and clr_ovf.
REQ-031 Reset asserted during SEND SHALL force uart_wr low on the next edge; array contents need not be cleared.

Verification
REQ-032 Push 0x41,0x42,0x43 back-to-back, uart_busy model rising 1 cycle after uart_wr for 10 cycles -> three uart_wr pulses carrying 0x41,0x42,0x43 in order, none while busy; idle returns high.
REQ-033 Hold uart_busy high, push 17 bytes (DEPTH=16) -> full=1, count=16, overflow=1, 17th byte never sent; clr_ovf -> overflow=0.
REQ-034 Full queue, uart_busy low, push and dequeue in the same cycle -> count stays 16, overflow stays 0, the new byte is eventually sent last.
REQ-035 Push 40 bytes at a rate matched to drain, covering pointer wrap twice -> output sequence equals input sequence.
REQ-036 Assert flush with 5 queued and one byte in SEND -> that byte is strobed, then no further uart_wr; count=0.
REQ-037 Assert reset in SEND cycle -> next cycle uart_wr=0, count=0, overflow=0, idle=1 once uart_busy is low.
